// File: rtl/noc_output_port_allocator.sv
// Output-port allocator for the NoC router: round-robin arbitration with wormhole
// locking, downstream credit tracking and per-input turn restrictions.
module noc_output_port_allocator #(
    parameter int NUM_INPUTS        = 5,
    parameter int FLIT_BUFFER_DEPTH = 4,
    parameter int CREDIT_WIDTH      = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
    input  logic                    clk_noc,
    input  logic                    rst_noc,
    input  logic [NUM_INPUTS-1:0]   req,
    input  logic [NUM_INPUTS-1:0]   req_is_tail,
    input  logic [NUM_INPUTS-1:0]   turn_disable,
    input  logic                    credit_in,
    output logic [NUM_INPUTS-1:0]   grant,
    output logic                    send_out,
    output logic [CREDIT_WIDTH-1:0] credit_count,
    output logic                    locked,
    output logic                    err_credit_overflow
);

    localparam int PTR_WIDTH = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam logic [PTR_WIDTH-1:0]    LAST_IDX   = PTR_WIDTH'(NUM_INPUTS - 1);
    localparam logic [CREDIT_WIDTH-1:0] MAX_CREDIT = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t                  state_q, state_d;
    logic [PTR_WIDTH-1:0]    rr_ptr_q, rr_ptr_d;
    logic [PTR_WIDTH-1:0]    owner_q, owner_d;
    logic [CREDIT_WIDTH-1:0] credit_q, credit_d;
    logic                    err_q, err_d;

    logic [NUM_INPUTS-1:0]   eligible;
    logic [NUM_INPUTS-1:0]   grant_c;
    logic                    send_c;
    logic                    found;
    logic [PTR_WIDTH-1:0]    winner;
    logic [PTR_WIDTH-1:0]    cand;
    logic                    has_credit;

    function automatic logic [PTR_WIDTH-1:0] next_ptr(input logic [PTR_WIDTH-1:0] p);
        return (p == LAST_IDX) ? '0 : p + PTR_WIDTH'(1);
    endfunction

    always_ff @(posedge clk_noc or posedge rst_noc) begin
        if (rst_noc) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            credit_q <= MAX_CREDIT;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            credit_q <= credit_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        credit_d   = credit_q;
        err_d      = err_q;
        grant_c    = '0;
        send_c     = 1'b0;
        found      = 1'b0;
        winner     = '0;
        cand       = rr_ptr_q;
        has_credit = (credit_q != '0);
        eligible   = req & ~turn_disable;

        // Walk the inputs starting at the round-robin pointer; first eligible one wins.
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (!found && eligible[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
            cand = next_ptr(cand);
        end

        case (state_q)
            IDLE: begin
                if (found && has_credit) begin
                    grant_c[winner] = 1'b1;
                    send_c          = 1'b1;
                    if (req_is_tail[winner]) begin
                        rr_ptr_d = next_ptr(winner);
                    end else begin
                        state_d = LOCKED;
                        owner_d = winner;
                    end
                end
            end
            LOCKED: begin
                grant_c[owner_q] = 1'b1;
                send_c           = req[owner_q] && has_credit;
                if (send_c && req_is_tail[owner_q]) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr(owner_q);
                end
            end
            default: state_d = IDLE;
        endcase

        // A credit returned at a full counter is dropped and flagged.
        case ({send_c, credit_in})
            2'b10: credit_d = credit_q - CREDIT_WIDTH'(1);
            2'b01: begin
                if (credit_q == MAX_CREDIT) begin
                    err_d = 1'b1;
                end else begin
                    credit_d = credit_q + CREDIT_WIDTH'(1);
                end
            end
            default: credit_d = credit_q;
        endcase
    end

    assign grant               = rst_noc ? '0 : grant_c;
    assign send_out            = !rst_noc && send_c;
    assign locked              = !rst_noc && (state_q == LOCKED);
    assign credit_count        = credit_q;
    assign err_credit_overflow = err_q;

endmodule

// File: tb/tb_noc_output_port_allocator.sv
// Bench for noc_output_port_allocator: directed cases with literal expectations and a
// randomized run checked every cycle against a behavioural model of the port.
module tb_noc_output_port_allocator;

    localparam int N     = 5;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk_noc = 1'b0;
    logic          rst_noc = 1'b1;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  req_is_tail = '0;
    logic [N-1:0]  turn_disable = '0;
    logic          credit_in = 1'b0;
    logic [N-1:0]  grant;
    logic          send_out;
    logic [CW-1:0] credit_count;
    logic          locked;
    logic          err_credit_overflow;

    int tests_run    = 0;
    int tests_failed = 0;

    // Model of the port: who owns the link, where round-robin resumes, credits held.
    bit m_locked;
    int m_owner;
    int m_ptr;
    int m_credits;
    bit m_err;

    noc_output_port_allocator #(
        .NUM_INPUTS(N),
        .FLIT_BUFFER_DEPTH(DEPTH)
    ) dut (
        .clk_noc(clk_noc),
        .rst_noc(rst_noc),
        .req(req),
        .req_is_tail(req_is_tail),
        .turn_disable(turn_disable),
        .credit_in(credit_in),
        .grant(grant),
        .send_out(send_out),
        .credit_count(credit_count),
        .locked(locked),
        .err_credit_overflow(err_credit_overflow)
    );

    always #5 clk_noc = ~clk_noc;

    // Inputs are stable between the negedge and the next posedge, so the model
    // predicts this cycle's outputs and then advances to the post-edge state.
    always @(negedge clk_noc) begin : compareModel
        logic [N-1:0] eg;
        logic         es;
        int           ec;
        bit           el;
        bit           ee;
        int           w;
        int           idx;
        eg = '0;
        es = 1'b0;
        if (rst_noc) begin
            ec        = DEPTH;
            el        = 1'b0;
            ee        = 1'b0;
            m_locked  = 1'b0;
            m_owner   = 0;
            m_ptr     = 0;
            m_credits = DEPTH;
            m_err     = 1'b0;
        end else begin
            ec = m_credits;
            el = m_locked;
            ee = m_err;
            if (!m_locked) begin
                w = -1;
                if (m_credits > 0) begin
                    for (int k = 0; k < N; k++) begin
                        idx = (m_ptr + k) % N;
                        if (w < 0 && req[idx] && !turn_disable[idx]) w = idx;
                    end
                end
                if (w >= 0) begin
                    eg[w] = 1'b1;
                    es    = 1'b1;
                    if (req_is_tail[w]) begin
                        m_ptr = (w + 1) % N;
                    end else begin
                        m_locked = 1'b1;
                        m_owner  = w;
                    end
                end
            end else begin
                eg[m_owner] = 1'b1;
                es          = req[m_owner] && (m_credits > 0);
                if (es && req_is_tail[m_owner]) begin
                    m_locked = 1'b0;
                    m_ptr    = (m_owner + 1) % N;
                end
            end
            m_credits = m_credits - int'(es) + int'(credit_in);
            if (m_credits > DEPTH) begin
                m_credits = DEPTH;
                m_err     = 1'b1;
            end
        end
        tests_run++;
        if (grant !== eg || send_out !== es || credit_count !== CW'(ec) ||
            locked !== el || err_credit_overflow !== ee) begin
            tests_failed++;
            $display("[TB] FAIL model_cycle t=%0t: got grant=%b send=%b credits=%0d locked=%b err=%b, expected grant=%b send=%b credits=%0d locked=%b err=%b",
                     $time, grant, send_out, credit_count, locked, err_credit_overflow,
                     eg, es, ec, el, ee);
        end
    end

    task automatic applyStimulus(input logic [N-1:0] r, input logic [N-1:0] t,
                                 input logic [N-1:0] d, input logic c);
        @(posedge clk_noc);
        #1;
        req          = r;
        req_is_tail  = t;
        turn_disable = d;
        credit_in    = c;
    endtask

    task automatic checkOutput(input string name, input logic [N-1:0] eg, input logic es,
                               input int ec, input logic el, input logic ee);
        tests_run++;
        if (grant !== eg || send_out !== es || credit_count !== CW'(ec) ||
            locked !== el || err_credit_overflow !== ee) begin
            tests_failed++;
            $display("[TB] FAIL %s: got grant=%b send=%b credits=%0d locked=%b err=%b, expected grant=%b send=%b credits=%0d locked=%b err=%b",
                     name, grant, send_out, credit_count, locked, err_credit_overflow,
                     eg, es, ec, el, ee);
        end
    endtask

    task automatic applyAndCheck(input string name, input logic [N-1:0] r, input logic [N-1:0] t,
                                 input logic [N-1:0] d, input logic c,
                                 input logic [N-1:0] eg, input logic es, input int ec,
                                 input logic el, input logic ee);
        applyStimulus(r, t, d, c);
        @(negedge clk_noc);
        checkOutput(name, eg, es, ec, el, ee);
    endtask

    // Requests stay asserted during reset so the output gating is exercised.
    task automatic resetDut();
        @(posedge clk_noc);
        #1;
        rst_noc      = 1'b1;
        req          = '1;
        req_is_tail  = '1;
        turn_disable = '0;
        credit_in    = 1'b0;
        @(posedge clk_noc);
        @(posedge clk_noc);
        #1;
        rst_noc     = 1'b0;
        req         = '0;
        req_is_tail = '0;
    endtask

    initial begin
        resetDut();
        applyAndCheck("single_flit_local", 5'b00001, 5'b00001, '0, 1'b0, 5'b00001, 1'b1, 4, 1'b0, 1'b0);
        applyAndCheck("after_single_flit", '0, '0, '0, 1'b0, '0, 1'b0, 3, 1'b0, 1'b0);

        resetDut();
        applyAndCheck("rr_alt_1", 5'b10010, 5'b11111, '0, 1'b0, 5'b00010, 1'b1, 4, 1'b0, 1'b0);
        applyAndCheck("rr_alt_2", 5'b10010, 5'b11111, '0, 1'b0, 5'b10000, 1'b1, 3, 1'b0, 1'b0);
        applyAndCheck("rr_alt_3", 5'b10010, 5'b11111, '0, 1'b0, 5'b00010, 1'b1, 2, 1'b0, 1'b0);
        applyAndCheck("rr_alt_4", 5'b10010, 5'b11111, '0, 1'b0, 5'b10000, 1'b1, 1, 1'b0, 1'b0);
        applyAndCheck("no_credit_stall", 5'b10010, 5'b11111, '0, 1'b0, '0, 1'b0, 0, 1'b0, 1'b0);
        applyAndCheck("credit_return", 5'b10010, 5'b11111, '0, 1'b1, '0, 1'b0, 0, 1'b0, 1'b0);
        applyAndCheck("credit_reused", 5'b10010, 5'b11111, '0, 1'b0, 5'b00010, 1'b1, 1, 1'b0, 1'b0);
        applyAndCheck("credit_spent", 5'b10010, 5'b11111, '0, 1'b0, '0, 1'b0, 0, 1'b0, 1'b0);

        resetDut();
        applyAndCheck("wormhole_head", 5'b00110, 5'b00000, '0, 1'b0, 5'b00010, 1'b1, 4, 1'b0, 1'b0);
        applyAndCheck("wormhole_body", 5'b00110, 5'b00000, '0, 1'b0, 5'b00010, 1'b1, 3, 1'b1, 1'b0);
        applyAndCheck("bubble_1", 5'b00100, 5'b00100, '0, 1'b0, 5'b00010, 1'b0, 2, 1'b1, 1'b0);
        applyAndCheck("bubble_2", 5'b00100, 5'b00100, 5'b00010, 1'b0, 5'b00010, 1'b0, 2, 1'b1, 1'b0);
        applyAndCheck("wormhole_tail", 5'b00110, 5'b00010, '0, 1'b0, 5'b00010, 1'b1, 2, 1'b1, 1'b0);
        applyAndCheck("next_after_tail", 5'b00100, 5'b00100, '0, 1'b0, 5'b00100, 1'b1, 1, 1'b0, 1'b0);

        resetDut();
        applyAndCheck("send_to_3", 5'b00001, 5'b00001, '0, 1'b0, 5'b00001, 1'b1, 4, 1'b0, 1'b0);
        applyAndCheck("send_to_2", 5'b00001, 5'b00001, '0, 1'b0, 5'b00001, 1'b1, 3, 1'b0, 1'b0);
        applyAndCheck("send_and_credit", 5'b00001, 5'b00001, '0, 1'b1, 5'b00001, 1'b1, 2, 1'b0, 1'b0);
        applyAndCheck("count_held", '0, '0, '0, 1'b0, '0, 1'b0, 2, 1'b0, 1'b0);

        resetDut();
        applyAndCheck("turn_disabled", 5'b01000, 5'b01000, 5'b01000, 1'b0, '0, 1'b0, 4, 1'b0, 1'b0);
        applyAndCheck("overflow_cycle", '0, '0, '0, 1'b1, '0, 1'b0, 4, 1'b0, 1'b0);
        applyAndCheck("overflow_sticky", '0, '0, '0, 1'b0, '0, 1'b0, 4, 1'b0, 1'b1);

        resetDut();
        applyAndCheck("mid_pkt_head", 5'b00001, '0, '0, 1'b0, 5'b00001, 1'b1, 4, 1'b0, 1'b0);
        applyAndCheck("mid_pkt_body", 5'b00001, '0, '0, 1'b0, 5'b00001, 1'b1, 3, 1'b1, 1'b0);
        @(posedge clk_noc);
        #1;
        rst_noc = 1'b1;
        #1;
        checkOutput("reset_mid_packet", '0, 1'b0, 4, 1'b0, 1'b0);
        @(posedge clk_noc);
        #1;
        rst_noc = 1'b0;
        req     = '0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 299) == 0) begin
                resetDut();
            end else begin
                applyStimulus(N'($urandom), N'($urandom), N'($urandom & $urandom & $urandom),
                              ($urandom_range(0, 2) == 0));
            end
        end

        @(negedge clk_noc);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
